// File: rtl/adc_serial_reader.sv
// ---------------------------------------------------------------------------
// adc_serial_reader
//
// Serial ADC front end for the door controller's GPIO peripheral. Runs one
// conversion on an ADC0831-style serial converter per start request. It
// drives chip select and a divided serial clock, shifts the result in MSB
// first, and presents it as a parallel word with a one-cycle valid strobe.
//
// Parameters:
//   HALF_PERIOD  clk cycles per sclk half period (>= 1)
//   DATA_BITS    number of result bits captured, MSB first
//   LEAD_BITS    leading sclk rising edges whose samples are discarded (>= 0)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   init   in   start-conversion request, level-sampled, honoured only when idle
//   sdata  in   serial data from the ADC
//   cs_n   out  ADC chip select, active low
//   sclk   out  serial clock to the ADC
//   data   out  last completed conversion result
//   valid  out  one-cycle strobe, data updated this cycle
//   busy   out  high while a conversion is in progress
// ---------------------------------------------------------------------------
module adc_serial_reader #(
  parameter int HALF_PERIOD = 50000,
  parameter int DATA_BITS   = 8,
  parameter int LEAD_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy
);

  // Total number of sclk rising edges in one conversion.
  localparam int N = LEAD_BITS + DATA_BITS;

  // The half-period counter only has to reach HALF_PERIOD-1. The bit counter
  // has to reach N. Both are kept at least one bit wide so that HALF_PERIOD=1
  // still elaborates cleanly.
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(N);
  localparam logic [BW-1:0] LEAD_LAST = BW'(LEAD_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [HW-1:0]        half_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 half_tick;
  logic [BW-1:0]        bit_next;

  // half_tick marks the clk edge where sclk changes level. bit_next is the
  // index of the rising edge that is about to happen, numbered from 1.
  assign half_tick = (half_cnt == HALF_LAST);
  assign bit_next  = bit_cnt + BW'(1);

  // Single sequencer for the whole conversion. Every output is a register.
  //
  // The DONE cycle is handled exactly like IDLE. The result is already
  // published on the edge that enters DONE, so init can be honoured on the
  // very next edge. This is why held-high init gives back-to-back conversions
  // with cs_n high for only one cycle.
  //
  // In SHIFT, sdata is captured on the same edge that drives sclk high. The
  // first LEAD_BITS captures are thrown away. The rest enter at the LSB, so
  // the first kept bit ends up as the MSB. On the falling-edge time that
  // follows rising edge N, the shift register is published, and chip select
  // and busy are released in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          sclk     <= 1'b0;
          half_cnt <= '0;
          bit_cnt  <= '0;
          if (init) begin
            state <= SHIFT;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            shreg <= '0;
          end else begin
            state <= IDLE;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        SHIFT: begin
          if (half_tick) begin
            half_cnt <= '0;
            if (!sclk) begin
              sclk    <= 1'b1;
              bit_cnt <= bit_next;
              if (bit_next > LEAD_LAST) begin
                shreg <= (shreg << 1) | DATA_BITS'(sdata);
              end
            end else if (bit_cnt == BITS_LAST) begin
              state <= DONE;
              sclk  <= 1'b0;
              cs_n  <= 1'b1;
              busy  <= 1'b0;
              valid <= 1'b1;
              data  <= shreg;
            end else begin
              sclk <= 1'b0;
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_reader
//
// Bench for adc_serial_reader. It builds two instances. Instance A uses
// HALF_PERIOD=2, LEAD_BITS=1 and DATA_BITS=8. Instance B uses HALF_PERIOD=1,
// LEAD_BITS=0 and DATA_BITS=8. Each conversion pushes its expected word into
// a per-instance queue when the stimulus starts. A monitor pops and compares
// that word whenever the instance raises valid. The sclk, cs_n, busy and
// valid outputs are predicted cycle by cycle from the conversion timing.
// ---------------------------------------------------------------------------
module tb_adc_serial_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_a = 1'b0;
  logic       sdata_a = 1'b0;
  logic       init_b = 1'b0;
  logic       sdata_b = 1'b0;
  logic       cs_n_a, sclk_a, valid_a, busy_a;
  logic       cs_n_b, sclk_b, valid_b, busy_b;
  logic [7:0] data_a, data_b;

  int         total = 0;
  int         bad = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  adc_serial_reader #(.HALF_PERIOD(2), .DATA_BITS(8), .LEAD_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .init(init_a), .sdata(sdata_a),
    .cs_n(cs_n_a), .sclk(sclk_a), .data(data_a), .valid(valid_a), .busy(busy_a)
  );

  adc_serial_reader #(.HALF_PERIOD(1), .DATA_BITS(8), .LEAD_BITS(0)) dut_b (
    .clk(clk), .reset(reset), .init(init_b), .sdata(sdata_b),
    .cs_n(cs_n_b), .sclk(sclk_b), .data(data_b), .valid(valid_b), .busy(busy_b)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard monitor: each valid strobe must match the oldest pending word.
  always begin
    @(posedge clk);
    #1;
    if (valid_a === 1'b1) begin
      if (qa.size() == 0) checkOutput("A_unexpected_valid", valid_a, 0);
      else checkOutput("A_data", data_a, qa.pop_front());
    end
    if (valid_b === 1'b1) begin
      if (qb.size() == 0) checkOutput("B_unexpected_valid", valid_b, 0);
      else checkOutput("B_data", data_b, qb.pop_front());
    end
  end

  task automatic driveIn(input bit sel, input logic i, input logic s);
    if (sel) begin
      init_b  = i;
      sdata_b = s;
    end else begin
      init_a  = i;
      sdata_a = s;
    end
  endtask

  // Checks the idle output values of one instance in the current cycle.
  task automatic checkIdle(input bit sel, input string tag, input logic [7:0] want_data);
    string p;
    p = sel ? "B_" : "A_";
    checkOutput({p, tag, "_cs_n"},  sel ? cs_n_b  : cs_n_a,  1);
    checkOutput({p, tag, "_sclk"},  sel ? sclk_b  : sclk_a,  0);
    checkOutput({p, tag, "_busy"},  sel ? busy_b  : busy_a,  0);
    checkOutput({p, tag, "_valid"}, sel ? valid_b : valid_a, 0);
    checkOutput({p, tag, "_data"},  sel ? data_b  : data_a,  32'(want_data));
  endtask

  // Serial bit the ADC presents before the edge that ends cycle t0+j-1.
  // Edges that are not sclk rising edges, and discarded lead bits, get noise.
  function automatic logic sampleFor(input int j, input int h, input int lead,
                                     input logic [7:0] word, input bit all_ones);
    int m;
    int k;
    if (all_ones) return 1'b1;
    if ((j - 1) % h == 0) begin
      m = (j - 1) / h;
      if (m % 2 == 1) begin
        k = (m + 1) / 2;
        if (k > lead && k <= lead + 8) return word[8 - (k - lead)];
      end
    end
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one conversion. The caller is #1 after a posedge, so the current
  // cycle is t0, and init is raised during it. Loop iteration j observes
  // cycle t0+j. repulse_at re-raises init during that cycle. abort_at raises
  // reset during that cycle. hold_init leaves init high at the end.
  task automatic applyStimulus(input bit sel, input int h, input int lead, input logic [7:0] word,
                               input bit hold_init, input bit all_ones,
                               input int repulse_at, input int abort_at);
    int    n;
    int    t;
    int    tog;
    string p;
    n = lead + 8;
    t = 2 * n * h + 1;
    p = sel ? "B_" : "A_";
    if (abort_at == 0) begin
      if (sel) qb.push_back(word);
      else qa.push_back(word);
    end
    driveIn(sel, 1'b1, sampleFor(1, h, lead, word, all_ones));
    for (int j = 1; j <= t; j++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && j == abort_at + 1) begin
        checkIdle(sel, "abort", 8'h00);
        reset = 1'b0;
        return;
      end
      tog = (j - 1) / h;
      if (tog > 2 * n) tog = 2 * n;
      checkOutput({p, "sclk"},  sel ? sclk_b  : sclk_a,  32'(tog % 2));
      checkOutput({p, "cs_n"},  sel ? cs_n_b  : cs_n_a,  32'(j == t));
      checkOutput({p, "busy"},  sel ? busy_b  : busy_a,  32'(j != t));
      checkOutput({p, "valid"}, sel ? valid_b : valid_a, 32'(j == t));
      driveIn(sel, 1'(hold_init || j == repulse_at), sampleFor(j + 1, h, lead, word, all_ones));
      if (j == abort_at) reset = 1'b1;
    end
    if (!hold_init) begin
      @(posedge clk);
      #1;
      checkIdle(sel, "after", word);
    end
  endtask

  initial begin
    logic [7:0] rnd;
    $display("[TB] start");

    // Reset held for three cycles while sdata toggles, then released.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sdata_a = ~sdata_a;
      sdata_b = ~sdata_b;
      @(posedge clk);
      #1;
      checkIdle(1'b0, "reset", 8'h00);
      checkIdle(1'b1, "reset", 8'h00);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkIdle(1'b0, "post_reset", 8'h00);
      checkIdle(1'b1, "post_reset", 8'h00);
    end

    // Single conversion, then the same conversion with init re-pulsed mid-way.
    applyStimulus(1'b0, 2, 1, 8'hB2, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 2, 1, 8'hB2, 1'b0, 1'b0, 10, 0);
    rnd = 8'($urandom_range(0, 255));
    applyStimulus(1'b0, 2, 1, rnd, 1'b0, 1'b0, 0, 0);

    // Back-to-back conversions with init held high and sdata at 1.
    applyStimulus(1'b0, 2, 1, 8'hFF, 1'b1, 1'b1, 0, 0);
    applyStimulus(1'b0, 2, 1, 8'hFF, 1'b0, 1'b1, 0, 0);

    // Abort mid-conversion, then a clean full conversion.
    applyStimulus(1'b0, 2, 1, 8'h5A, 1'b0, 1'b0, 0, 20);
    @(posedge clk);
    #1;
    checkIdle(1'b0, "abort_hold", 8'h00);
    applyStimulus(1'b0, 2, 1, 8'h3C, 1'b0, 1'b0, 0, 0);

    // Fastest sclk, no lead bits.
    applyStimulus(1'b1, 1, 0, 8'h81, 1'b0, 1'b0, 0, 0);
    rnd = 8'($urandom_range(0, 255));
    applyStimulus(1'b1, 1, 0, rnd, 1'b0, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("A_pending_results", qa.size(), 0);
    checkOutput("B_pending_results", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
